// File: rtl/monitor_erros_pkg.sv
// Shared definitions for the 2-bit adder error monitor.
// Holds the controller state encoding, the counter word indices used on
// out_id, and the number of words streamed per window.
package monitor_erros_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLETA   = 2'd1,
        DESCARGA = 2'd2
    } estado_t;

    localparam logic [2:0] ID_TOTAL   = 3'd0;
    localparam logic [2:0] ID_BIT0    = 3'd1;
    localparam logic [2:0] ID_BIT1    = 3'd2;
    localparam logic [2:0] ID_BIT2    = 3'd3;
    localparam logic [2:0] ID_PALAVRA = 3'd4;

    localparam int NUM_PALAVRAS = 5;

endpackage

// File: rtl/ref_soma_2bits.sv
// Golden 2-bit adder, purely combinational.
// Ports:
//   a_i    [1:0]  operand A
//   b_i    [1:0]  operand B
//   soma_o [2:0]  A + B, carry in bit 2
module ref_soma_2bits (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [2:0] soma_o
);

    assign soma_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/monitor_erros_soma.sv
// Error monitor for the 2-bit adder under study.
// Collects N_AMOSTRAS samples (A, B, S), compares S with the golden sum and
// counts samples, per-bit mismatches and per-word mismatches, then streams the
// five counters out with a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a window (honoured in IDLE only)
//   in_valid/in_ready   sample handshake; in_a, in_b, in_s sample data
//   out_valid/out_ready word handshake; out_id index, out_dado counter value
//   busy                high outside IDLE
//   done                one-cycle pulse after the last word handshake
//
// state    | meaning
// IDLE     | waiting for start, counters hold last window
// COLETA   | accepting samples until N_AMOSTRAS are counted
// DESCARGA | streaming words id0..id4
module monitor_erros_soma
    import monitor_erros_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int N_AMOSTRAS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    input  logic [2:0]       in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_id,
    output logic [CNT_W-1:0] out_dado,
    output logic             busy,
    output logic             done
);

    generate
        if (N_AMOSTRAS < 1 || N_AMOSTRAS > (2 ** CNT_W) - 1) begin : g_param_err
            $error("monitor_erros_soma: N_AMOSTRAS out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_AMOSTRAS);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_PALAVRAS];
    logic [CNT_W-1:0] cnt_d [NUM_PALAVRAS];
    logic [2:0]       out_id_q, out_id_d;
    logic             done_q, done_d;

    logic [2:0]       golden;
    logic [2:0]       diff;
    logic [CNT_W-1:0] total_inc;

    ref_soma_2bits u_ref (
        .a_i    (in_a),
        .b_i    (in_b),
        .soma_o (golden)
    );

    assign diff      = golden ^ in_s;
    assign total_inc = cnt_q[ID_TOTAL] + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_id_d = out_id_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_PALAVRAS; i++) cnt_d[i] = '0;
                    out_id_d = ID_TOTAL;
                    state_d  = COLETA;
                end
            end
            COLETA: begin
                if (in_valid) begin
                    cnt_d[ID_TOTAL]   = total_inc;
                    cnt_d[ID_BIT0]    = cnt_q[ID_BIT0] + CNT_W'(diff[0]);
                    cnt_d[ID_BIT1]    = cnt_q[ID_BIT1] + CNT_W'(diff[1]);
                    cnt_d[ID_BIT2]    = cnt_q[ID_BIT2] + CNT_W'(diff[2]);
                    cnt_d[ID_PALAVRA] = cnt_q[ID_PALAVRA] + CNT_W'(|diff);
                    // in_ready is decoded from state, so leaving COLETA here
                    // guarantees no sample beyond the N-th is counted.
                    if (total_inc == N_LIM) state_d = DESCARGA;
                end
            end
            DESCARGA: begin
                if (out_ready) begin
                    if (out_id_q == ID_PALAVRA) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        out_id_d = out_id_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            for (int i = 0; i < NUM_PALAVRAS; i++) cnt_q[i] <= '0;
            out_id_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_id_q <= out_id_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        out_dado = '0;
        case (out_id_q)
            ID_TOTAL:   out_dado = cnt_q[ID_TOTAL];
            ID_BIT0:    out_dado = cnt_q[ID_BIT0];
            ID_BIT1:    out_dado = cnt_q[ID_BIT1];
            ID_BIT2:    out_dado = cnt_q[ID_BIT2];
            ID_PALAVRA: out_dado = cnt_q[ID_PALAVRA];
            default:    out_dado = '0;
        endcase
    end

    assign in_ready  = (state_q == COLETA);
    assign out_valid = (state_q == DESCARGA);
    assign busy      = (state_q != IDLE);
    assign out_id    = out_id_q;
    assign done      = done_q;

endmodule
